uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serialises one 8-bit byte per write into an asynchronous UART frame on TxD. It is the stage directly upstream of uart_receiver, and TxD connects straight to the receiver's RxD. The frame format is 1 start bit (0), 8 data bits LSB-first, 1 even-parity bit and 1 stop bit (1). Baud generation uses the same 3-bit baud_select table and 16x sample-tick structure as the receiver, so the two blocks interoperate bit-exactly.

Parameters:
OVERSAMPLE, 16, sample ticks per serial bit; fixed, must match uart_receiver.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset; 0 resets all state
baud_select  input  3  rate select: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200
Tx_EN  input  1  transmitter enable
Tx_WR  input  1  one-cycle write strobe
Tx_DATA  input  8  byte to send, sampled when the write is accepted
TxD  output  1  serial line; idles at 1
Tx_BUSY  output  1  high from write accept until the end of the stop bit

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; TxD=1; Tx_BUSY=0.
  - Shift register, parity register and all counters = 0.
  - Takes effect immediately, including mid-frame; no partial frame resumes after reset releases.
- Baud tick:
  - Divisor DIV per baud_select 000..111 = 10417, 2604, 651, 326, 163, 81, 54, 27.
  - Tick counter counts 0..DIV-1 and pulses a tick for 1 cycle at DIV-1.
  - Counter is held at 0 in IDLE and cleared on write accept.
  - baud_select is latched at write accept; changes mid-frame are ignored.
- Bit timing:
  - Each serial bit lasts exactly OVERSAMPLE ticks = 16*DIV clocks (baud 111: 432 clocks = 8640 ns).
- Write accept:
  - Accepted when Tx_WR=1, Tx_EN=1 and state=IDLE at a rising clk edge.
  - On accept: latch Tx_DATA; compute parity = XOR of the 8 data bits, so the total count of ones in data+parity is even.
  - Latency: TxD=0 and Tx_BUSY=1 from the cycle after accept.
  - Writes during BUSY are ignored: no queueing, no corruption of the current frame.
  - Writes with Tx_EN=0 are ignored.
- FSM:
  - IDLE -> START on accept.
  - START -> DATA after 16 ticks.
  - DATA: 3-bit index 0..7; TxD=data[index]; index increments every 16 ticks; after index 7 -> PARITY.
  - PARITY -> STOP after 16 ticks.
  - STOP (TxD=1) -> IDLE after 16 ticks; Tx_BUSY falls the cycle that IDLE is entered.
- Frame length: 11 bits = 176*DIV clocks from the first TxD=0 cycle to Tx_BUSY=0.
- Back-to-back frames: a write in the first IDLE cycle is accepted. The minimum gap between frames is then 1 idle clock at TxD=1, which is acceptable to the receiver.
- Tx_EN low mid-frame: abort to IDLE on the next edge; TxD=1 and Tx_BUSY=0 from the following cycle.
- TxD is driven from a register: no combinational path from inputs, glitch-free.

Test Plan:
- Reset: hold reset=0 for 400 ns with Tx_WR pulsing -> TxD=1 and Tx_BUSY=0 throughout; no frame appears after release.
- Normal frame, baud 111: write 8'h85 -> TxD sequence 0, 1,0,1,0,0,0,0,1, parity 1, stop 1; each bit 432 clocks; Tx_BUSY high for exactly 4752 clocks. A uart_receiver loopback yields Rx_DATA=8'h85, Rx_VALID=1, Rx_PERROR=0, Rx_FERROR=0.
- Parity coverage: write 8'h00 -> parity 0; write 8'hFF -> parity 0; write 8'h01 -> parity 1.
- Write while busy: write 8'h85, then 8'h3C at clock 1000 of the frame -> the 8'h3C write is ignored and the frame still carries 8'h85. A second write issued after Tx_BUSY falls sends 8'h3C.
- Rate and latch: baud 011, write 8'hA5 -> bit width 5216 clocks. Switching baud_select to 111 mid-frame leaves the bit width at 5216 until the frame ends.
- Abort: deassert Tx_EN during D3 -> TxD=1 and Tx_BUSY=0 two edges later. A write with Tx_EN=0 produces no frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: sends one byte per write as a frame of start, 8 data bits LSB-first,
// even parity and stop. Timing is 16 baud ticks per bit, and every output is registered.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Clock divisor per baud sample tick; this must stay identical to the receiver's table.
  function automatic logic [13:0] baud_div(input logic [2:0] sel);
    logic [13:0] div;
    case (sel)
      3'b000:  div = 14'd10417;
      3'b001:  div = 14'd2604;
      3'b010:  div = 14'd651;
      3'b011:  div = 14'd326;
      3'b100:  div = 14'd163;
      3'b101:  div = 14'd81;
      3'b110:  div = 14'd54;
      default: div = 14'd27;
    endcase
    return div;
  endfunction

  state_t            state_q, state_d;
  logic [13:0]       div_last_q, div_last_d;
  logic [13:0]       tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;

  logic              tick;
  logic              bit_done;

  assign tick     = (tick_cnt_q == div_last_q);
  assign bit_done = tick && (os_cnt_q == OS_LAST);

  always_comb begin
    state_d    = state_q;
    div_last_d = div_last_q;
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    busy_d     = busy_q;

    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
      os_cnt_d   = '0;
      bit_idx_d  = '0;
      txd_d      = 1'b1;
      busy_d     = 1'b0;
      if (Tx_WR && Tx_EN) begin
        state_d    = S_START;
        div_last_d = baud_div(baud_select) - 14'd1;
        shift_d    = Tx_DATA;
        parity_d   = ^Tx_DATA;
        txd_d      = 1'b0;
        busy_d     = 1'b1;
      end
    end else if (!Tx_EN) begin
      // Abort: go idle now; TxD/Tx_BUSY return to idle values one edge later from IDLE.
      state_d    = S_IDLE;
      tick_cnt_d = '0;
      os_cnt_d   = '0;
      bit_idx_d  = '0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 14'd1;
      if (tick) begin
        os_cnt_d = os_cnt_q + OS_ONE;
      end
      if (bit_done) begin
        os_cnt_d = '0;
        case (state_q)
          S_START: begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            txd_d     = shift_q[0];
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              // shift_q[0] always holds the bit currently on the line
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
              txd_d     = shift_q[1];
            end
          end
          S_PARITY: begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end
          S_STOP: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_last_q <= '0;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_last_q <= div_last_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: expected frames are queued at each write and
// matched against a line monitor that checks every cycle of every bit.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         nbits;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_active = 1'b0;

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .Tx_EN      (Tx_EN),
    .Tx_WR      (Tx_WR),
    .Tx_DATA    (Tx_DATA),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int div_of(input logic [2:0] sel);
    case (sel)
      3'd0: return 10417;
      3'd1: return 2604;
      3'd2: return 651;
      3'd3: return 326;
      3'd4: return 163;
      3'd5: return 81;
      3'd6: return 54;
      default: return 27;
    endcase
  endfunction

  // Called at the negedge of the first TxD=0 cycle of a frame.
  task automatic monitor_frame();
    frame_t     e;
    int         w;
    logic       bits[11];
    int         good[11];
    logic [7:0] rx;
    int         busy_hi;
    int         n;
    mon_active = 1'b1;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_frame", 1, 0);
      for (int i = 0; i < 200000; i++) begin
        if (!Tx_BUSY) break;
        @(negedge clk);
      end
      mon_active = 1'b0;
      return;
    end
    e = exp_q.pop_front();
    w = 16 * e.div;
    bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) bits[b+1] = e.data[b];
    bits[9]  = ^e.data;
    bits[10] = 1'b1;
    for (int b = 0; b < 11; b++) good[b] = 0;
    rx = '0;
    busy_hi = 0;
    for (int i = 0; i < e.nbits * w; i++) begin
      int b;
      if (i > 0) @(negedge clk);
      b = i / w;
      if (TxD === bits[b]) good[b]++;
      if (Tx_BUSY === 1'b1) busy_hi++;
      if ((i % w) == (w / 2) && b >= 1 && b <= 8) rx[b-1] = TxD;
    end
    for (int b = 0; b < e.nbits; b++) begin
      check_eq($sformatf("bit%0d_width_d%02h", b, e.data), good[b], w);
    end
    if (e.nbits == 11) begin
      check_eq("rx_data", rx, e.data);
      check_eq("busy_clocks", busy_hi, 11 * w);
      @(negedge clk);
      check_eq("busy_end", Tx_BUSY, 0);
      check_eq("idle_txd", TxD, 1);
    end else begin
      n = 0;
      while (Tx_BUSY && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check_eq("abort_busy_low", Tx_BUSY, 0);
    end
    $display("frame data=%02h div=%0d bits=%0d rx=%02h", e.data, e.div, e.nbits, rx);
    mon_active = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && TxD === 1'b0 && Tx_BUSY === 1'b1) monitor_frame();
    end
  end

  // Caller drives from away from the rising edge; the write is seen at the next posedge.
  task automatic do_write(input logic [7:0] d, input logic [2:0] sel, input bit expect_acc,
                          input int nbits);
    frame_t f;
    if (expect_acc) begin
      f.data  = d;
      f.div   = div_of(sel);
      f.nbits = nbits;
      exp_q.push_back(f);
    end
    Tx_DATA     = d;
    baud_select = sel;
    Tx_WR       = 1'b1;
    @(posedge clk);
    #1;
    Tx_WR = 1'b0;
    $display("write data=%02h sel=%0d en=%0b expect_accept=%0b", d, sel, Tx_EN, expect_acc);
    if (expect_acc) begin
      check_eq("accept_txd", TxD, 0);
      check_eq("accept_busy", Tx_BUSY, 1);
    end
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_active) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("done_timeout", ok, 1);
  endtask

  task automatic count_busy(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int w3;
    reset       = 1'b0;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h77;
    baud_select = 3'b111;

    // Reset held for 400 ns while writes keep arriving.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      Tx_WR = i[0];
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
    end
    check_eq("reset_hold_bad", bad, 0);
    check_eq("reset_txd", TxD, 1);
    check_eq("reset_busy", Tx_BUSY, 0);
    Tx_WR = 1'b0;
    reset = 1'b1;
    count_busy(500, bad);
    check_eq("post_reset_idle", bad, 0);

    // Parity coverage at 115200.
    @(negedge clk); do_write(8'h00, 3'b111, 1'b1, 11); wait_done(10000);
    @(negedge clk); do_write(8'hFF, 3'b111, 1'b1, 11); wait_done(10000);
    @(negedge clk); do_write(8'h01, 3'b111, 1'b1, 11); wait_done(10000);

    // Write while busy is dropped; a write in the first idle cycle is taken.
    @(negedge clk); do_write(8'h85, 3'b111, 1'b1, 11);
    repeat (998) @(posedge clk);
    #1;
    do_write(8'h3C, 3'b111, 1'b0, 11);
    bad = 1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!Tx_BUSY) begin
        bad = 0;
        break;
      end
    end
    check_eq("busy_fall_timeout", bad, 0);
    do_write(8'h3C, 3'b111, 1'b1, 11);
    wait_done(10000);

    // Baud latched at accept, then abort during D3.
    w3 = 16 * div_of(3'b011);
    @(negedge clk); do_write(8'hA5, 3'b011, 1'b1, 4);
    repeat (2999) @(posedge clk);
    #1;
    baud_select = 3'b111;
    repeat (4 * w3 + 100 - 3000) @(posedge clk);
    #1;
    check_eq("abort_pre_txd", TxD, 0);
    check_eq("abort_pre_busy", Tx_BUSY, 1);
    Tx_EN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("abort_txd", TxD, 1);
    check_eq("abort_busy", Tx_BUSY, 0);
    wait_done(2000);

    // Disabled write produces nothing.
    @(negedge clk); do_write(8'h5A, 3'b111, 1'b0, 11);
    count_busy(500, bad);
    check_eq("en_low_idle", bad, 0);

    // Clean frame after the abort.
    Tx_EN = 1'b1;
    @(negedge clk); do_write(8'hC3, 3'b111, 1'b1, 11); wait_done(10000);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
